// File: rtl/sp_instr_fifo_packer.sv
// Producer side of the scratchpad read-instruction FIFO: expands row-range
// requests into (mat, row) slots and packs four slots per FIFO word.
module sp_instr_fifo_packer #(
  parameter int MAT_W        = 4,
  parameter int ROW_W        = 3,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [MAT_W-1:0]               req_mat,
  input  logic [ROW_W-1:0]               req_row,
  input  logic [ROW_W:0]                 req_cnt,
  input  logic                           flush,
  input  logic                           instr_FIFO_full,
  output logic                           instr_FIFO_WEN,
  output logic [4*(1+MAT_W+ROW_W)-1:0]   instr_FIFO_wdata,
  output logic                           busy
);

  localparam int S  = 1 + MAT_W + ROW_W;
  localparam int CW = ROW_W + 1;
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = {1'b1, {ROW_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_PUSH,
    ST_WAIT
  } state_t;

  state_t             state;

  logic [MAT_W-1:0]   w_mat_q, w_mat_d;
  logic [ROW_W-1:0]   w_row_q, w_row_d;
  logic [CW-1:0]      w_rem_q, w_rem_d;
  logic [3:0][S-1:0]  buf_q, buf_d;
  logic [2:0]         f_q, f_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               fp_q, fp_d;

  logic               accept;
  logic               push;
  logic [2:0]         room;
  logic [2:0]         k;
  logic [2:0]         pos;
  logic [CW-1:0]      sat_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      w_mat_q <= '0;
      w_row_q <= '0;
      w_rem_q <= '0;
      buf_q   <= '0;
      f_q     <= '0;
      idle_q  <= '0;
      fp_q    <= 1'b0;
    end else begin
      w_mat_q <= w_mat_d;
      w_row_q <= w_row_d;
      w_rem_q <= w_rem_d;
      buf_q   <= buf_d;
      f_q     <= f_d;
      idle_q  <= idle_d;
      fp_q    <= fp_d;
    end
  end

  always_comb begin
    w_mat_d   = w_mat_q;
    w_row_d   = w_row_q;
    w_rem_d   = w_rem_q;
    buf_d     = buf_q;
    f_d       = f_q;
    idle_d    = idle_q;
    fp_d      = fp_q;
    pos       = '0;
    room      = 3'd4 - f_q;
    k         = '0;
    sat_cnt   = (req_cnt > MAX_CNT) ? MAX_CNT : req_cnt;

    // Full words and flush/timeout-driven partial words share one push path.
    if (f_q == 3'd4 ||
        (f_q != '0 && w_rem_q == '0 && (fp_q || idle_q == IW'(FLUSH_CYCLES))))
      state = ST_PUSH;
    else if (w_rem_q != '0)
      state = ST_PACK;
    else if (f_q == '0)
      state = ST_IDLE;
    else
      state = ST_WAIT;

    req_ready = (w_rem_q == '0) && !(f_q == 3'd4 && instr_FIFO_full);
    accept    = req_valid && req_ready;
    push      = (state == ST_PUSH) && !instr_FIFO_full;

    case (state)
      ST_PUSH: begin
        if (push) begin
          buf_d = '0;
          f_d   = '0;
        end
      end
      ST_PACK: begin
        k = (w_rem_q < CW'(room)) ? 3'(w_rem_q) : room;
        for (int unsigned j = 0; j < 4; j++) begin
          pos = 3'(j);
          if (pos >= f_q && pos < f_q + k)
            buf_d[j] = {1'b1, w_mat_q, w_row_q + ROW_W'(pos - f_q)};
        end
        w_row_d = w_row_q + ROW_W'(k);
        w_rem_d = w_rem_q - CW'(k);
        f_d     = f_q + k;
      end
      default: ;
    endcase

    // Acceptance requires an empty walker, so it never overlaps a PACK cycle.
    if (accept) begin
      w_mat_d = req_mat;
      w_row_d = req_row;
      w_rem_d = sat_cnt;
    end

    if (accept || push || (f_d != f_q))
      idle_d = '0;
    else if (f_q != '0 && w_rem_q == '0 && !req_valid && idle_q != IW'(FLUSH_CYCLES))
      idle_d = idle_q + 1'b1;

    // A flush seen mid-walk is held until the walker drains.
    if ((push && w_rem_q == '0) || (f_q == '0 && w_rem_q == '0))
      fp_d = 1'b0;
    else if (flush)
      fp_d = 1'b1;
  end

  assign instr_FIFO_WEN   = push;
  assign instr_FIFO_wdata = buf_q;
  assign busy             = (w_rem_q != '0) || (f_q != '0);

endmodule

// File: tb/tb_sp_instr_fifo_packer.sv
// Directed bench for sp_instr_fifo_packer: hand-computed packed words,
// timing of pushes, backpressure, flush, saturation and reset behaviour.
module tb_sp_instr_fifo_packer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_mat;
  logic [2:0]  req_row;
  logic [3:0]  req_cnt;
  logic        flush;
  logic        instr_FIFO_full;
  logic        instr_FIFO_WEN;
  logic [31:0] instr_FIFO_wdata;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;
  int base;

  sp_instr_fifo_packer #(
    .MAT_W(4),
    .ROW_W(3),
    .FLUSH_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mat(req_mat),
    .req_row(req_row),
    .req_cnt(req_cnt),
    .flush(flush),
    .instr_FIFO_full(instr_FIFO_full),
    .instr_FIFO_WEN(instr_FIFO_WEN),
    .instr_FIFO_wdata(instr_FIFO_wdata),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (instr_FIFO_WEN === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic [3:0] m, input logic [2:0] r, input logic [3:0] c);
    req_valid = 1'b1;
    req_mat   = m;
    req_row   = r;
    req_cnt   = c;
    #1;
  endtask

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_mat = '0; req_row = '0; req_cnt = '0;
    flush = 1'b0; instr_FIFO_full = 1'b0;
    tick(); tick();
    chk("rst_wen", 32'(instr_FIFO_WEN), 32'd0);
    chk("rst_wdata", instr_FIFO_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    nRST = 1'b1;
    tick();

    // Wrap and split: (3,6,6)
    base = wr_count;
    req(4'd3, 3'd6, 4'd6);
    chk("t1_ready_c0", 32'(req_ready), 32'd1);
    tick(); req_valid = 1'b0;
    chk("t1_wen_c1", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    chk("t1_wen_c2", 32'(instr_FIFO_WEN), 32'd1);
    chk("t1_word_c2", instr_FIFO_wdata, 32'h99989F9E);
    tick();
    chk("t1_wen_c3", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    chk("t1_ready_c4", 32'(req_ready), 32'd1);
    chk("t1_busy_c4", 32'(busy), 32'd1);
    tick(); tick(); tick();
    chk("t1_wen_c7", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    chk("t1_wen_c8", 32'(instr_FIFO_WEN), 32'd1);
    chk("t1_word_c8", instr_FIFO_wdata, 32'h00009B9A);
    tick();
    chk("t1_busy_c9", 32'(busy), 32'd0);
    chk("t1_writes", 32'(wr_count - base), 32'd2);

    // Cross-request coalescing: (1,0,2) then (2,5,3)
    base = wr_count;
    req(4'd1, 3'd0, 4'd2);
    chk("t2_ready_c0", 32'(req_ready), 32'd1);
    tick();
    req(4'd2, 3'd5, 4'd3);
    chk("t2_ready_c1", 32'(req_ready), 32'd0);
    tick();
    chk("t2_ready_c2", 32'(req_ready), 32'd1);
    tick(); req_valid = 1'b0;
    chk("t2_wen_c3", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    chk("t2_wen_c4", 32'(instr_FIFO_WEN), 32'd1);
    chk("t2_word_c4", instr_FIFO_wdata, 32'h96958988);
    tick();
    chk("t2_wen_c5", 32'(instr_FIFO_WEN), 32'd0);
    tick(); tick(); tick(); tick();
    chk("t2_wen_c9", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    chk("t2_wen_c10", 32'(instr_FIFO_WEN), 32'd1);
    chk("t2_word_c10", instr_FIFO_wdata, 32'h00000097);
    tick();
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_writes", 32'(wr_count - base), 32'd2);

    // Backpressure: (5,0,4) with FIFO full for 10 cycles
    base = wr_count;
    instr_FIFO_full = 1'b1;
    req(4'd5, 3'd0, 4'd4);
    tick(); req_valid = 1'b0;
    chk("t3_wen_c1", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_stall_wen_%0d", i), 32'(instr_FIFO_WEN), 32'd0);
      chk($sformatf("t3_stall_word_%0d", i), instr_FIFO_wdata, 32'hABAAA9A8);
      chk($sformatf("t3_stall_ready_%0d", i), 32'(req_ready), 32'd0);
      tick();
    end
    instr_FIFO_full = 1'b0;
    #1;
    chk("t3_release_wen", 32'(instr_FIFO_WEN), 32'd1);
    chk("t3_release_word", instr_FIFO_wdata, 32'hABAAA9A8);
    tick();
    chk("t3_after_wen", 32'(instr_FIFO_WEN), 32'd0);
    chk("t3_after_busy", 32'(busy), 32'd0);
    chk("t3_writes", 32'(wr_count - base), 32'd1);

    // Explicit flush with one slot buffered: (6,2,1)
    base = wr_count;
    req(4'd6, 3'd2, 4'd1);
    tick(); req_valid = 1'b0;
    tick();
    flush = 1'b1;
    chk("t4_wen_c2", 32'(instr_FIFO_WEN), 32'd0);
    tick(); flush = 1'b0;
    chk("t4_wen_c3", 32'(instr_FIFO_WEN), 32'd1);
    chk("t4_word_c3", instr_FIFO_wdata, 32'h000000B2);
    tick();
    chk("t4_busy_c4", 32'(busy), 32'd0);
    chk("t4_writes", 32'(wr_count - base), 32'd1);

    // Flush while empty: no write
    base = wr_count;
    flush = 1'b1;
    tick(); flush = 1'b0;
    repeat (6) tick();
    chk("t4_idle_flush_writes", 32'(wr_count - base), 32'd0);
    chk("t4_idle_flush_busy", 32'(busy), 32'd0);

    // Flush during a cnt=8 walk: (7,0,8)
    base = wr_count;
    req(4'd7, 3'd0, 4'd8);
    tick(); req_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    chk("t4b_wen_c2", 32'(instr_FIFO_WEN), 32'd1);
    chk("t4b_word_c2", instr_FIFO_wdata, 32'hBBBAB9B8);
    tick();
    chk("t4b_wen_c3", 32'(instr_FIFO_WEN), 32'd0);
    tick();
    chk("t4b_wen_c4", 32'(instr_FIFO_WEN), 32'd1);
    chk("t4b_word_c4", instr_FIFO_wdata, 32'hBFBEBDBC);
    tick();
    chk("t4b_busy_c5", 32'(busy), 32'd0);
    repeat (8) tick();
    chk("t4b_writes", 32'(wr_count - base), 32'd2);

    // Zero count: accepted, nothing packed
    base = wr_count;
    req(4'd9, 3'd1, 4'd0);
    chk("t5_zero_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = 1'b0;
    chk("t5_zero_busy_c1", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("t5_zero_busy", 32'(busy), 32'd0);
    chk("t5_zero_writes", 32'(wr_count - base), 32'd0);

    // Saturating count: (4,3,15) emits exactly 8 slots
    base = wr_count;
    req(4'd4, 3'd3, 4'd15);
    tick(); req_valid = 1'b0;
    tick();
    chk("t5_sat_wen_c2", 32'(instr_FIFO_WEN), 32'd1);
    chk("t5_sat_word_c2", instr_FIFO_wdata, 32'hA6A5A4A3);
    tick(); tick();
    chk("t5_sat_wen_c4", 32'(instr_FIFO_WEN), 32'd1);
    chk("t5_sat_word_c4", instr_FIFO_wdata, 32'hA2A1A0A7);
    tick();
    chk("t5_sat_busy_c5", 32'(busy), 32'd0);
    repeat (8) tick();
    chk("t5_sat_writes", 32'(wr_count - base), 32'd2);

    // Reset during a stalled push with w_rem=3: (8,0,7)
    base = wr_count;
    instr_FIFO_full = 1'b1;
    req(4'd8, 3'd0, 4'd7);
    tick(); req_valid = 1'b0;
    tick();
    chk("t6_stall_busy", 32'(busy), 32'd1);
    chk("t6_stall_wen", 32'(instr_FIFO_WEN), 32'd0);
    chk("t6_stall_ready", 32'(req_ready), 32'd0);
    tick();
    nRST = 1'b0;
    #1;
    chk("t6_rst_wen", 32'(instr_FIFO_WEN), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_wdata", instr_FIFO_wdata, 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd1);
    instr_FIFO_full = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    #1;
    chk("t6_post_ready", 32'(req_ready), 32'd1);
    repeat (10) tick();
    chk("t6_post_writes", 32'(wr_count - base), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp_instr_fifo_packer.md
Name: sp_instr_fifo_packer

Overview:
- Producer side of the scratchpad read-instruction FIFO.
- Accepts row-range read requests of the form (matrix, start row, row count) from the tensor-core controller.
- Expands each request into individual (mat_sel, row_sel) slots and packs four slots per FIFO word, one slot per scratchpad read port 1..4.
- Writes packed words into the instruction FIFO; the scratchpad-side FSM pops them and drives the four read selects.

Parameters:
- MAT_W, 4, width of the matrix select field (mat_s_t).
- ROW_W, 3, width of the row select field (row_s_t); a matrix has 2^ROW_W rows.
- FLUSH_CYCLES, 4, idle cycles before a partially filled word is pushed automatically.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_mat  input  MAT_W  matrix select.
- req_row  input  ROW_W  first row.
- req_cnt  input  ROW_W+1  row count, 0..2^ROW_W; larger values saturate to 2^ROW_W.
- flush  input  1  single-cycle pulse; push any partial word as soon as possible.
- instr_FIFO_full  input  1  FIFO cannot accept a write.
- instr_FIFO_WEN  output  1  FIFO write enable.
- instr_FIFO_wdata  output  4*(1+MAT_W+ROW_W)  packed word.
- busy  output  1  walker or pack buffer non-empty.

Behaviour:
- Word format:
  - Slot i (0..3) occupies bits [i*S +: S], with S = 1+MAT_W+ROW_W.
  - Within a slot, MSB to LSB: {vld, mat, row}.
  - Slot i feeds read port i+1. Unused slots are all-zero.
- Registered state:
  - Walker: w_mat, w_row, w_rem.
  - Pack buffer: 4 slots plus fill count f (0..4).
  - idle_cnt and flush_pending.
- Reset (asynchronous, any time, including mid-request or mid-push):
  - All state clears to zero.
  - Outputs: instr_FIFO_WEN=0, instr_FIFO_wdata=0, busy=0, req_ready=1.
  - In-flight requests and partial words are discarded.
- req_ready = (w_rem==0) and no push is stalled with f==4. Acceptance loads the walker; packing starts the next cycle. req_cnt=0 is accepted and produces no slots.
- States, derived from registers:
  - IDLE: f==0 and w_rem==0.
  - PACK: w_rem>0 and f<4.
  - PUSH: f==4, or (f>0, w_rem==0, and either flush_pending or idle_cnt==FLUSH_CYCLES).
- PACK, each cycle:
  - k = min(w_rem, 4-f) slots are written at positions f..f+k-1 with rows w_row, w_row+1, ..., computed mod 2^ROW_W (wrap-around is legal).
  - Then w_row += k (mod), w_rem -= k, f += k.
  - Up to 4 slots are packed per cycle.
- PUSH:
  - instr_FIFO_WEN = !instr_FIFO_full, combinational from registered state; wdata is the pack buffer.
  - On a write, f and all slots clear at the next edge.
  - No packing occurs in a PUSH cycle.
  - While full, state holds, WEN=0, and wdata stays stable.
- Auto-flush:
  - idle_cnt increments while f>0, w_rem==0, !req_valid.
  - idle_cnt clears on any acceptance, any fill change, or any push.
- Flush:
  - flush sets flush_pending.
  - flush_pending clears on a push that occurs with w_rem==0, or immediately if f==0 and w_rem==0.
  - A flush during PACK waits until the walker drains, so full words are pushed first, then the partial word.
- Latency: accept at cycle t → first full word WEN at t+2 when the FIFO is not full.
- busy = (w_rem!=0) | (f!=0).

Test Plan:
- Wrap and split: req mat=3, row=6, cnt=6 accepted at cycle 0, FIFO not full.
  - Cycle 2: WEN=1, slots (3,6),(3,7),(3,0),(3,1), vld mask 1111.
  - Cycle 4: f=2, req_ready=1.
  - Cycle 8: partial word (3,2),(3,3), mask 0011, upper slots zero.
- Cross-request coalescing:
  - req mat=1, row=0, cnt=2, then mat=2, row=5, cnt=3 back to back.
  - Result: first word (1,0),(1,1),(2,5),(2,6); later auto-flush word (2,7), mask 0001.
- Backpressure:
  - instr_FIFO_full=1 for 10 cycles with f==4 → WEN=0, wdata stable, req_ready=0.
  - Full deasserted → exactly one WEN pulse with the unchanged word.
- Explicit flush:
  - f=1, flush pulse → WEN on the next cycle, mask 0001.
  - Flush with f=0, w_rem=0 → no write.
  - Flush during cnt=8 → two full words, no extra write.
- Zero/saturate: req_cnt=0 → no slots, busy stays 0; req_cnt=15 with ROW_W=3 → exactly 8 slots emitted.
- Reset mid-operation:
  - nRST low during PUSH stall with w_rem=3 → WEN=0 immediately, busy=0.
  - After release, req_ready=1 and no stale word is ever written.
